// File: rtl/sink_if.sv
// valid/ready stream interface shared by the incrementing-data source and the sink.
interface valid_ready #(
    parameter int DATA_WIDTH = 8
);
    logic                  valid;
    logic                  ready;
    logic [DATA_WIDTH-1:0] data;

    modport Master (output valid, output data, input ready);
    modport Slave  (input valid, input data, output ready);
endinterface

// File: rtl/sink.sv
// Stream sink: throttles ready by a programmable idle delay and checks for a +1 sequence from 1.
// Optional SINK_RESYNC_EN: on a mismatch the checker re-locks to the incoming word.
module sink #(
    parameter int DATA_WIDTH  = 8,
    parameter int DELAY_BITS  = 3,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [DELAY_BITS-1:0]  delay,
    valid_ready.Slave              vrBus,
    output logic [DATA_WIDTH-1:0]  last_data,
    output logic [COUNT_WIDTH-1:0] rx_count,
    output logic [COUNT_WIDTH-1:0] err_count,
    output logic                   error
);

    typedef enum logic [2:0] {
        RESET_STATE   = 3'b001,
        PROCESS_DELAY = 3'b010,
        WAIT_DATA     = 3'b100
    } state_t;

    state_t                 state_q, state_d;
    logic [DELAY_BITS-1:0]  delay_count_q, delay_count_d;
    logic [DATA_WIDTH-1:0]  expected_q, expected_d;
    logic [DATA_WIDTH-1:0]  last_data_q, last_data_d;
    logic [COUNT_WIDTH-1:0] rx_count_q, rx_count_d;
    logic [COUNT_WIDTH-1:0] err_count_q, err_count_d;
    logic                   error_q, error_d;

    logic [DELAY_BITS:0]    count_next;
    logic                   handshake;
    logic                   mismatch;

    // Ready comes straight off the state register, so valid and delay never reach it combinationally.
    assign vrBus.ready = (state_q == WAIT_DATA);
    assign handshake   = vrBus.valid && (state_q == WAIT_DATA);
    assign mismatch    = (vrBus.data != expected_q);
    assign count_next  = {1'b0, delay_count_q} + {{DELAY_BITS{1'b0}}, 1'b1};

    always_comb begin
        state_d       = state_q;
        delay_count_d = delay_count_q;
        expected_d    = expected_q;
        last_data_d   = last_data_q;
        rx_count_d    = rx_count_q;
        err_count_d   = err_count_q;
        error_d       = error_q;

        unique case (state_q)
            RESET_STATE: begin
                delay_count_d = '0;
                state_d       = (delay == '0) ? WAIT_DATA : PROCESS_DELAY;
            end
            PROCESS_DELAY: begin
                delay_count_d = count_next[DELAY_BITS-1:0];
                // Compare against the live delay so a lowered delay exits on the next edge.
                if (count_next >= {1'b0, delay})
                    state_d = WAIT_DATA;
            end
            WAIT_DATA: begin
                if (handshake) begin
                    last_data_d = vrBus.data;
                    if (rx_count_q != '1)
                        rx_count_d = rx_count_q + COUNT_WIDTH'(1);
                    if (mismatch) begin
                        error_d = 1'b1;
                        if (err_count_q != '1)
                            err_count_d = err_count_q + COUNT_WIDTH'(1);
                    end
`ifdef SINK_RESYNC_EN
                    expected_d = mismatch ? vrBus.data + DATA_WIDTH'(1)
                                          : expected_q + DATA_WIDTH'(1);
`else
                    expected_d = expected_q + DATA_WIDTH'(1);
`endif
                    delay_count_d = '0;
                    state_d       = (delay == '0) ? WAIT_DATA : PROCESS_DELAY;
                end
            end
            default: begin
                state_d = RESET_STATE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= RESET_STATE;
            delay_count_q <= '0;
            expected_q    <= DATA_WIDTH'(1);
            last_data_q   <= '0;
            rx_count_q    <= '0;
            err_count_q   <= '0;
            error_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            delay_count_q <= delay_count_d;
            expected_q    <= expected_d;
            last_data_q   <= last_data_d;
            rx_count_q    <= rx_count_d;
            err_count_q   <= err_count_d;
            error_q       <= error_d;
        end
    end

    assign last_data = last_data_q;
    assign rx_count  = rx_count_q;
    assign err_count = err_count_q;
    assign error     = error_q;

endmodule

// File: tb/tb_sink.sv
// Directed bench for sink: delay throttling, back-to-back, wrap, skip, idle and async reset.
module tb_sink;

    logic        clk;
    logic        reset;
    logic [2:0]  delay;
    logic [7:0]  last_data;
    logic [15:0] rx_count;
    logic [15:0] err_count;
    logic        error;

    int vectors;
    int miscompares;

    valid_ready #(.DATA_WIDTH(8)) vr ();

    sink #(.DATA_WIDTH(8), .DELAY_BITS(3), .COUNT_WIDTH(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .delay     (delay),
        .vrBus     (vr),
        .last_data (last_data),
        .rx_count  (rx_count),
        .err_count (err_count),
        .error     (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one word and returns how many negedges it took to be accepted (0 on timeout).
    task automatic send(input logic [7:0] w, output int n);
        vr.valid = 1'b1;
        vr.data  = w;
        n = 0;
        for (int k = 0; k < 50; k++) begin
            logic hs;
            hs = vr.ready;
            @(negedge clk);
            n++;
            if (hs) return;
        end
        vectors++;
        miscompares++;
        $display("FAIL send_timeout word=%0d got no handshake within 50 cycles", w);
        n = 0;
    endtask

    task automatic do_reset(input logic [2:0] d);
        vr.valid = 1'b0;
        vr.data  = 8'd0;
        delay    = d;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset;
        int n;
        vr.valid = 1'b0;
        vr.data  = 8'd0;
        delay    = 3'd3;
        reset    = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if ({vr.ready, last_data, rx_count, err_count, error} !== 42'd0) begin
            miscompares++;
            $display("FAIL reset_state got ready=%b last=%0d rx=%0d err=%0d error=%b want all 0",
                     vr.ready, last_data, rx_count, err_count, error);
        end
        reset = 1'b1;
        send(8'd1, n);
        vectors++;
        if (n !== 5) begin
            miscompares++;
            $display("FAIL first_ready_latency got %0d want 5", n);
        end
        for (int w = 2; w <= 3; w++) begin
            send(8'(w), n);
            vectors++;
            if (n !== 4) begin
                miscompares++;
                $display("FAIL delay3_spacing word=%0d got %0d want 4", w, n);
            end
        end
        vr.valid = 1'b0;
        vectors++;
        if (rx_count !== 16'd3 || last_data !== 8'd3 || error !== 1'b0) begin
            miscompares++;
            $display("FAIL delay3_status got rx=%0d last=%0d error=%b want 3 3 0",
                     rx_count, last_data, error);
        end
    endtask

    task automatic test_back_to_back;
        int n, total;
        do_reset(3'd0);
        send(8'd1, n);
        vectors++;
        if (n !== 2) begin
            miscompares++;
            $display("FAIL b2b_first got %0d want 2", n);
        end
        total = 0;
        for (int w = 2; w <= 10; w++) begin
            send(8'(w), n);
            total += n;
        end
        vr.valid = 1'b0;
        vectors++;
        if (total !== 9) begin
            miscompares++;
            $display("FAIL b2b_cycles got %0d want 9", total);
        end
        vectors++;
        if (rx_count !== 16'd10 || err_count !== 16'd0 || last_data !== 8'd10) begin
            miscompares++;
            $display("FAIL b2b_status got rx=%0d err=%0d last=%0d want 10 0 10",
                     rx_count, err_count, last_data);
        end
    endtask

    task automatic test_wrap;
        int n;
        do_reset(3'd0);
        for (int i = 1; i <= 300; i++) send(8'(i), n);
        vr.valid = 1'b0;
        vectors++;
        if (rx_count !== 16'd300 || err_count !== 16'd0 || last_data !== 8'd44 || error !== 1'b0) begin
            miscompares++;
            $display("FAIL wrap_status got rx=%0d err=%0d last=%0d error=%b want 300 0 44 0",
                     rx_count, err_count, last_data, error);
        end
    endtask

    task automatic test_skip;
        int n;
        logic [7:0] words [7];
        logic [15:0] exp_err;
        words = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd6, 8'd7, 8'd8};
`ifdef SINK_RESYNC_EN
        exp_err = 16'd1;
`else
        exp_err = 16'd3;
`endif
        do_reset(3'd1);
        for (int i = 0; i < 4; i++) send(words[i], n);
        vectors++;
        if (error !== 1'b0 || err_count !== 16'd0) begin
            miscompares++;
            $display("FAIL skip_clean_prefix got err=%0d error=%b want 0 0", err_count, error);
        end
        for (int i = 4; i < 7; i++) send(words[i], n);
        vr.valid = 1'b0;
        vectors++;
        if (err_count !== exp_err || error !== 1'b1 || rx_count !== 16'd7) begin
            miscompares++;
            $display("FAIL skip_status got err=%0d error=%b rx=%0d want %0d 1 7",
                     err_count, error, rx_count, exp_err);
        end
    endtask

    task automatic test_idle_valid;
        int n;
        int bad;
        do_reset(3'd0);
        send(8'd1, n);
        vr.valid = 1'b0;
        vr.data  = 8'd77;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (vr.ready !== 1'b1 || rx_count !== 16'd1) bad++;
        end
        vectors++;
        if (bad !== 0) begin
            miscompares++;
            $display("FAIL idle_no_change got %0d bad cycles (rx=%0d) want 0", bad, rx_count);
        end
        vr.valid = 1'b1;
        vr.data  = 8'd2;
        @(negedge clk);
        vr.valid = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if (rx_count !== 16'd2 || last_data !== 8'd2 || err_count !== 16'd0) begin
            miscompares++;
            $display("FAIL idle_single_hs got rx=%0d last=%0d err=%0d want 2 2 0",
                     rx_count, last_data, err_count);
        end
    endtask

    task automatic test_async_reset;
        int n;
        do_reset(3'd2);
        for (int w = 1; w <= 5; w++) send(8'(w), n);
        vr.valid = 1'b1;
        vr.data  = 8'd6;
        vectors++;
        if (rx_count !== 16'd5 || vr.ready !== 1'b0) begin
            miscompares++;
            $display("FAIL pre_reset got rx=%0d ready=%b want 5 0", rx_count, vr.ready);
        end
        #2 reset = 1'b0;
        #1;
        vectors++;
        if ({vr.ready, last_data, rx_count, err_count, error} !== 42'd0) begin
            miscompares++;
            $display("FAIL async_reset got ready=%b last=%0d rx=%0d err=%0d error=%b want all 0",
                     vr.ready, last_data, rx_count, err_count, error);
        end
        @(negedge clk);
        reset = 1'b1;
        send(8'd1, n);
        vr.valid = 1'b0;
        vectors++;
        if (rx_count !== 16'd1 || last_data !== 8'd1 || err_count !== 16'd0 || error !== 1'b0) begin
            miscompares++;
            $display("FAIL restart got rx=%0d last=%0d err=%0d error=%b want 1 1 0 0",
                     rx_count, last_data, err_count, error);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b0;
        delay       = 3'd0;
        vr.valid    = 1'b0;
        vr.data     = 8'd0;
        test_reset();
        test_back_to_back();
        test_wrap();
        test_skip();
        test_idle_valid();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sink.md
Name: sink

Overview:
- Receiving end of the valid_ready stream produced by the team's incrementing-data source.
- Throttles acceptance by asserting ready only after a programmable idle delay following each handshake.
- Checks that received words form a continuous +1 sequence starting at 1.
- Exposes sequence status (last word, transfer count, error count, sticky error flag) for the testbench or top level.

Parameters:
- DATA_WIDTH, 8, width of vrBus.data and last_data.
- DELAY_BITS, 3, width of the delay input.
- COUNT_WIDTH, 16, width of rx_count and err_count.

Ports:
- clk  input  1  system clock; all state changes on posedge.
- reset  input  1  asynchronous, active-low reset.
- delay  input  DELAY_BITS  number of ready-low idle cycles between handshakes; 0 means back-to-back.
- vrBus  interface  valid_ready.Slave  samples valid and data (DATA_WIDTH); drives ready.
- last_data  output  DATA_WIDTH  data word captured at the most recent handshake.
- rx_count  output  COUNT_WIDTH  number of handshakes completed; saturating.
- err_count  output  COUNT_WIDTH  number of sequence mismatches; saturating.
- error  output  1  sticky; set on the first mismatch.

Behaviour:
- Reset (reset low, asynchronous): state=RESET_STATE, ready=0, delay_count=0, expected=1, last_data=0, rx_count=0, err_count=0, error=0.
- States: one-hot RESET_STATE, PROCESS_DELAY, WAIT_DATA.
- ready is a pure decode of the registered state: ready=1 iff state==WAIT_DATA. No combinational path from valid or delay to ready.
- RESET_STATE, first clk edge after reset release:
  - If delay==0, go to WAIT_DATA.
  - Otherwise go to PROCESS_DELAY with delay_count=0.
- PROCESS_DELAY: delay_count increments every cycle.
  - Go to WAIT_DATA when delay_count+1 >= delay, using the delay value sampled in that cycle.
  - Result: ready stays low for exactly delay cycles when delay is stable.
  - If delay is lowered mid-count, exit on the next edge.
- WAIT_DATA: hold ready=1 until valid&&ready is seen at a posedge. At that edge:
  - last_data <= data.
  - rx_count increments, saturating at all-ones.
  - If data != expected: err_count increments (saturating) and error <= 1.
  - expected <= expected+1, wrapping modulo 2^DATA_WIDTH.
  - Next state: if delay==0, stay in WAIT_DATA (one word per cycle); otherwise go to PROCESS_DELAY with delay_count=0.
- valid without ready (outside WAIT_DATA) is ignored; no data is sampled.
- data is compared only at handshake edges. Changes while valid is high and ready is low are not checked.
- Reset asserted mid-transfer returns everything to its reset values immediately; a pending word is dropped.
- Latency: handshake to updated last_data, rx_count and error is 1 cycle (registered).
- Wrap: after word 2^DATA_WIDTH-1 the expected value is 0. A source that wraps 255->0 (DATA_WIDTH=8) is not an error.

Optional Feature:
- Macro: SINK_RESYNC_EN.
- Defined: on a mismatch, expected <= data+1, so the checker re-locks to the incoming stream. One corrupted or skipped word counts as exactly one error.
- Undefined: expected always advances by +1 independent of data, so a skipped word makes every subsequent word an error.

Test Plan:
- Reset release, delay=3, source always valid with data 1,2,3 -> ready low 1 cycle (RESET_STATE) plus 3 cycles, then high. Handshakes are spaced 4 cycles apart (3 idle + 1 transfer). rx_count=3, last_data=3, error=0.
- delay=0, source valid every cycle for 10 words -> ready held high continuously, 10 handshakes in 10 consecutive cycles, rx_count=10, err_count=0.
- DATA_WIDTH=8, 300 sequential words -> wrap 255->0 accepted, err_count=0, last_data=44 (300 mod 256).
- Source skips word 5 (sends 1,2,3,4,6,7,8):
  - Without SINK_RESYNC_EN: err_count=3, error=1.
  - With SINK_RESYNC_EN: err_count=1, error=1.
- Source holds valid low for 20 cycles while ready is high -> no count change. Then valid high for one cycle -> exactly one handshake.
- Assert reset while in PROCESS_DELAY with rx_count=5 -> all outputs 0 asynchronously. After release, the sequence restarts expecting 1.
